// File: rtl/key_pulse_bank.sv
// key_pulse_bank: per-channel synchroniser, debouncer and press/release event pulser for board keys.
// Auto-repeat while held is built only when KEY_PULSE_REPEAT_EN is defined.
module key_pulse_bank #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 600,
  parameter int unsigned EDGE_MODE       = 0,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 30000,
  parameter int unsigned REPEAT_PERIOD   = 6000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pulse,
  output logic                any_pulse
);

  localparam logic [CHANNELS-1:0] RAW_IDLE   = (ACTIVE_LOW != 32'd0) ? {CHANNELS{1'b1}}
                                                                      : {CHANNELS{1'b0}};
  localparam logic                EV_PRESS   = (EDGE_MODE == 32'd0) || (EDGE_MODE == 32'd2);
  localparam logic                EV_RELEASE = (EDGE_MODE == 32'd1) || (EDGE_MODE == 32'd2);
  localparam logic [CNT_W-1:0]    DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    UNARMED = 2'd0,
    IDLE    = 2'd1,
    HELD    = 2'd2,
    REPEAT  = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] s_c;
  logic [CHANNELS-1:0] level_d;
  logic [CHANNELS-1:0] pulse_d;
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    dcnt_q  [CHANNELS];
  logic [CNT_W-1:0]    dcnt_d  [CHANNELS];

`ifdef KEY_PULSE_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt_q [CHANNELS];
  logic [CNT_W-1:0] rcnt_d [CHANNELS];
`else
  // Repeat timing has no hardware in this build; fold it away explicitly.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Normalise to active-high "pressed" samples.
  assign s_c       = (ACTIVE_LOW != 32'd0) ? ~sync2_q : sync2_q;
  assign any_pulse = |pulse;

  // State, counters, synchronisers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
      level   <= '0;
      pulse   <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= UNARMED;
        dcnt_q[i]  <= '0;
`ifdef KEY_PULSE_REPEAT_EN
        rcnt_q[i]  <= '0;
`endif
      end
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      level   <= level_d;
      pulse   <= pulse_d;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
`ifdef KEY_PULSE_REPEAT_EN
        rcnt_q[i]  <= rcnt_d[i];
`endif
      end
    end
  end

  // Per-channel next-state, debounce counting and event decode.
  always_comb begin
    level_d = level;
    pulse_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
`ifdef KEY_PULSE_REPEAT_EN
      rcnt_d[i]  = rcnt_q[i];
`endif
      case (state_q[i])
        // Wait for a debounced release so a key held through reset never fires.
        UNARMED: begin
          if (s_c[i]) begin
            dcnt_d[i] = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
          end else begin
            dcnt_d[i] = sat_inc(dcnt_q[i]);
          end
        end
        IDLE: begin
          if (!s_c[i]) begin
            dcnt_d[i] = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i] = HELD;
            dcnt_d[i]  = '0;
            level_d[i] = 1'b1;
            pulse_d[i] = EV_PRESS;
`ifdef KEY_PULSE_REPEAT_EN
            rcnt_d[i]  = '0;
`endif
          end else begin
            dcnt_d[i] = sat_inc(dcnt_q[i]);
          end
        end
        HELD, REPEAT: begin
          if (s_c[i]) begin
            dcnt_d[i] = '0;
          end else if (dcnt_q[i] == DB_LAST) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
            level_d[i] = 1'b0;
            pulse_d[i] = EV_RELEASE;
          end else begin
            dcnt_d[i] = sat_inc(dcnt_q[i]);
          end
`ifdef KEY_PULSE_REPEAT_EN
          // An accepted release wins over a repeat due on the same edge.
          if (state_d[i] != IDLE) begin
            if ((state_q[i] == HELD) && (rcnt_q[i] == RD_LAST)) begin
              state_d[i] = REPEAT;
              dcnt_d[i]  = '0;
              rcnt_d[i]  = '0;
              pulse_d[i] = EV_PRESS;
            end else if ((state_q[i] == REPEAT) && (rcnt_q[i] == RP_LAST)) begin
              rcnt_d[i]  = '0;
              pulse_d[i] = EV_PRESS;
            end else begin
              rcnt_d[i] = sat_inc(rcnt_q[i]);
            end
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_pulse_bank.sv
// tb_key_pulse_bank: scoreboard bench for key_pulse_bank; press-only and press+release instances share stimulus.
module tb_key_pulse_bank;

  localparam int unsigned DB  = 4;
  localparam int unsigned LAT = DB + 2;

  typedef struct packed {
    int unsigned cyc;
    logic [1:0]  level;
    logic [1:0]  p0;
    logic [1:0]  p2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] level0, pulse0, level2, pulse2;
  logic       any0, any2;

  int unsigned cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;
  logic [1:0]  exp_lvl = 2'b00;
  exp_t        sb [$];

  key_pulse_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(0), .ACTIVE_LOW(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(16)
  ) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in),
    .level(level0), .pulse(pulse0), .any_pulse(any0)
  );

  key_pulse_bank #(
    .CHANNELS(2), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(2), .ACTIVE_LOW(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(16)
  ) dut2 (
    .clk(clk), .rst(rst), .key_in(key_in),
    .level(level2), .pulse(pulse2), .any_pulse(any2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int unsigned at, input logic [1:0] lvl,
                      input logic [1:0] p0, input logic [1:0] p2);
    exp_t e;
    e.cyc = at; e.level = lvl; e.p0 = p0; e.p2 = p2;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the channels in m (key low), hold, release; both channels idle and released on entry.
  task automatic tap(input logic [1:0] m, input int hold);
    key_in = key_in & ~m;
    push(cyc + LAT, m, m, m);
    wait_cyc(hold);
    key_in = key_in | m;
    push(cyc + LAT, 2'b00, 2'b00, m);
    wait_cyc(LAT + 4);
  endtask

  // Outputs are compared every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [1:0] ep0, ep2;
    ep0 = 2'b00;
    ep2 = 2'b00;
    if (mon_en) begin
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("sb_stale", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        exp_lvl = sb[0].level;
        ep0     = sb[0].p0;
        ep2     = sb[0].p2;
        void'(sb.pop_front());
      end
      check("level0", 32'(level0), 32'(exp_lvl));
      check("level2", 32'(level2), 32'(exp_lvl));
      check("pulse0", 32'(pulse0), 32'(ep0));
      check("pulse2", 32'(pulse2), 32'(ep2));
      check("any0",   32'(any0),   32'(|ep0));
      check("any2",   32'(any2),   32'(|ep2));
    end
  end

  initial begin
    rst    = 1'b1;
    key_in = 2'b10;
    @(negedge clk);
    mon_en = 1'b1;
    wait_cyc(2);
    rst = 1'b0;

    // Key 0 held through reset and beyond must stay silent.
    wait_cyc(20);
    key_in[0] = 1'b1;
    wait_cyc(8);

    tap(2'b01, 10);

    // Bounce: three pressed samples then one released, five times.
    for (int k = 0; k < 5; k++) begin
      key_in[0] = 1'b0;
      wait_cyc(3);
      key_in[0] = 1'b1;
      wait_cyc(1);
    end
    tap(2'b01, 10);

    tap(2'b11, 10);
    tap(2'b10, 10);

`ifdef KEY_PULSE_REPEAT_EN
    begin
      int unsigned t;
      key_in[0] = 1'b0;
      t = cyc + LAT;
      push(t,      2'b01, 2'b01, 2'b01);
      push(t + 10, 2'b01, 2'b01, 2'b01);
      push(t + 15, 2'b01, 2'b01, 2'b01);
      push(t + 20, 2'b01, 2'b01, 2'b01);
      push(t + 25, 2'b01, 2'b01, 2'b01);
      wait_cyc(26);
      key_in[0] = 1'b1;
      push(cyc + LAT, 2'b00, 2'b00, 2'b01);
      wait_cyc(LAT + 14);
    end

    // Reset mid-repeat.
    key_in[0] = 1'b0;
    push(cyc + LAT, 2'b01, 2'b01, 2'b01);
    push(cyc + LAT + 10, 2'b01, 2'b01, 2'b01);
    wait_cyc(18);
    rst = 1'b1;
    push(cyc + 1, 2'b00, 2'b00, 2'b00);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(20);
    key_in[0] = 1'b1;
    wait_cyc(8);
    tap(2'b01, 10);
`else
    key_in[0] = 1'b0;
    push(cyc + LAT, 2'b01, 2'b01, 2'b01);
    wait_cyc(30);
    key_in[0] = 1'b1;
    push(cyc + LAT, 2'b00, 2'b00, 2'b01);
    wait_cyc(LAT + 4);
`endif

    // Reset mid-hold.
    key_in[0] = 1'b0;
    push(cyc + LAT, 2'b01, 2'b01, 2'b01);
    wait_cyc(10);
    rst = 1'b1;
    push(cyc + 1, 2'b00, 2'b00, 2'b00);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(20);
    key_in[0] = 1'b1;
    wait_cyc(8);
    tap(2'b01, 10);

    wait_cyc(10);
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
